// File: rtl/a2d_scanner.sv
// a2d_scanner: round-robin A2D channel sequencer. Takes four conversions per
// enabled channel, stores the truncated mean per channel and exposes the
// stored results through a registered read port. A conversion that never
// completes is abandoned after TMO_CYC wait cycles and flagged on err.
//
//  state   | meaning
//  --------+----------------------------------------------------------------
//  S_IDLE  | not scanning; channel pointer picked up from ch_mask on enable
//  S_START | one-cycle strt_cnv pulse for the channel in ptr
//  S_WAIT  | waiting for cnv_cmplt, timeout down-counter running
//  S_STORE | write mean of 4 samples (unless timed out), advance ptr

module a2d_scanner #(
    parameter int TMO_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic [7:0]  valid,
    output logic        scan_done,
    output logic        err
);

    localparam int TW = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_STORE
    } state_t;

    state_t        r_state;
    logic [2:0]    r_ptr;
    logic [13:0]   r_acc;
    logic [1:0]    r_cnt;
    logic [TW-1:0] r_tmr;
    logic          r_abort;
    logic          r_discard;
    logic          r_strt_cnv;
    logic [2:0]    r_chnnl;
    logic [7:0]    r_valid;
    logic          r_scan_done;
    logic          r_err;
    logic [11:0]   r_rd_data;
    logic [11:0]   r_result [8];

    logic [2:0]    w_adv_ptr;
    logic [2:0]    w_idle_ptr;
    logic          w_quit;

    // Next enabled channel above ptr (wrapping); a lone bit at ptr maps to itself.
    always_comb begin
        w_adv_ptr = r_ptr;
        for (int i = 7; i >= 1; i--) begin
            if (ch_mask[r_ptr + 3'(i)]) begin
                w_adv_ptr = r_ptr + 3'(i);
            end
        end
        w_idle_ptr = ch_mask[r_ptr] ? r_ptr : w_adv_ptr;
        w_quit     = r_abort | ~en;
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_acc       <= 14'd0;
            r_cnt       <= 2'd0;
            r_tmr       <= '0;
            r_abort     <= 1'b0;
            r_discard   <= 1'b0;
            r_strt_cnv  <= 1'b0;
            r_chnnl     <= 3'd0;
            r_valid     <= 8'h00;
            r_scan_done <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_result[i] <= 12'h000;
            end
        end else begin
            r_strt_cnv  <= 1'b0;
            r_scan_done <= 1'b0;
            if (!en) begin
                r_err <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_abort   <= 1'b0;
                    r_discard <= 1'b0;
                    r_acc     <= 14'd0;
                    r_cnt     <= 2'd0;
                    if (en && (ch_mask != 8'h00)) begin
                        r_ptr      <= w_idle_ptr;
                        r_chnnl    <= w_idle_ptr;
                        r_strt_cnv <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (!en) begin
                        r_abort <= 1'b1;
                    end
                    r_tmr   <= TW'(TMO_CYC - 1);
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!en) begin
                        r_abort <= 1'b1;
                    end
                    if (cnv_cmplt) begin
                        if (w_quit) begin
                            r_acc   <= 14'd0;
                            r_cnt   <= 2'd0;
                            r_state <= S_IDLE;
                        end else begin
                            r_acc <= r_acc + {2'b00, res};
                            r_cnt <= r_cnt + 2'd1;
                            if (r_cnt == 2'd3) begin
                                r_state <= S_STORE;
                            end else begin
                                r_strt_cnv <= 1'b1;
                                r_state    <= S_START;
                            end
                        end
                    end else if (r_tmr == '0) begin
                        if (w_quit) begin
                            r_acc   <= 14'd0;
                            r_cnt   <= 2'd0;
                            r_state <= S_IDLE;
                        end else begin
                            // Timed-out channel still advances through STORE so
                            // chnnl only moves there, but nothing is written.
                            r_err     <= 1'b1;
                            r_discard <= 1'b1;
                            r_state   <= S_STORE;
                        end
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end
                S_STORE: begin
                    if (!r_discard) begin
                        r_result[r_ptr] <= r_acc[13:2];
                        r_valid[r_ptr]  <= 1'b1;
                    end
                    r_acc     <= 14'd0;
                    r_cnt     <= 2'd0;
                    r_discard <= 1'b0;
                    if (ch_mask == 8'h00) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_ptr       <= w_adv_ptr;
                        r_chnnl     <= w_adv_ptr;
                        r_scan_done <= (w_adv_ptr <= r_ptr);
                        if (en) begin
                            r_strt_cnv <= 1'b1;
                            r_state    <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Registered read port; a same-cycle store shows up one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 12'h000;
        end else begin
            r_rd_data <= r_result[rd_ch];
        end
    end

    assign strt_cnv  = r_strt_cnv;
    assign chnnl     = r_chnnl;
    assign rd_data   = r_rd_data;
    assign valid     = r_valid;
    assign scan_done = r_scan_done;
    assign err       = r_err;

endmodule

// File: tb/tb_a2d_scanner.sv
// Self-checking bench for a2d_scanner: A2D interface model with random
// latency/results, plus a reference that derives scan order and averages
// from the channel mask and the logged conversion results.

module tb_a2d_scanner;

    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  ch_mask;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [2:0]  rd_ch;
    logic [11:0] rd_data;
    logic [7:0]  valid;
    logic        scan_done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // A2D model controls and logs
    int          lat_lo = 1;
    int          lat_hi = 3;
    logic [7:0]  noresp = 8'h00;
    logic [11:0] fixed_q [$];
    logic [2:0]  cmp_ch  [$];
    logic [11:0] cmp_val [$];

    // Monitor counters
    int sd_cnt   = 0;
    int strt_cnt = 0;
    int viol     = 0;

    always #5 clk = ~clk;

    a2d_scanner #(.TMO_CYC(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .ch_mask   (ch_mask),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .rd_ch     (rd_ch),
        .rd_data   (rd_data),
        .valid     (valid),
        .scan_done (scan_done),
        .err       (err)
    );

    // A2D interface model: one-cycle cnv_cmplt pulse a random time after strt_cnv
    initial begin
        bit         busy;
        int         lat;
        logic [2:0] cur;
        busy = 0; lat = 0; cur = 3'd0;
        cnv_cmplt = 1'b0;
        res = 12'h000;
        forever begin
            @(posedge clk); #1;
            cnv_cmplt = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else if (strt_cnv) begin
                busy = 1;
                cur  = chnnl;
                lat  = $urandom_range(lat_hi, lat_lo);
            end else if (busy) begin
                lat--;
                if (lat <= 0) begin
                    busy = 0;
                    if (!noresp[cur]) begin
                        if (fixed_q.size() > 0) res = fixed_q.pop_front();
                        else res = 12'($urandom_range(4095, 0));
                        cnv_cmplt = 1'b1;
                        cmp_ch.push_back(cur);
                        cmp_val.push_back(res);
                    end
                end
            end
        end
    end

    // Protocol monitor: strt_cnv single-cycle, chnnl stable while converting
    initial begin
        bit         prev_s;
        bit         trk;
        logic [2:0] held;
        prev_s = 0; trk = 0; held = 3'd0;
        forever begin
            @(posedge clk); #2;
            if (!rst_n) begin
                prev_s = 0;
                trk = 0;
            end else begin
                if (scan_done) sd_cnt++;
                if (strt_cnv) begin
                    strt_cnt++;
                    if (prev_s) viol++;
                    held = chnnl;
                    trk  = !noresp[chnnl];
                end else if (trk) begin
                    if (chnnl !== held) viol++;
                    if (cnv_cmplt) trk = 0;
                end
                prev_s = strt_cnv;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int sel, input logic [7:0] v);
        case (sel)
            0:       return strt_cnv === 1'b1;
            1:       return (valid & v) === v;
            2:       return scan_done === 1'b1;
            3:       return err === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic [7:0] v, input int budget,
                            input string tag, output int n);
        n = 0;
        while (!cond(sel, v)) begin
            if (n >= budget) begin
                checks++;
                errors++;
                $error("FAIL %s: timed out after %0d cycles", tag, budget);
                return;
            end
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        rst_n = 1'b0;
        noresp = 8'h00;
        lat_lo = 1;
        lat_hi = 3;
        fixed_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Reference: scan order is the set bits of the mask ascending from the lowest,
    // four samples per channel, result = floor(sum / 4); a trailing partial group
    // was aborted and leaves nothing behind. Expects the DUT idle.
    task automatic ref_check(input string tag, input logic [7:0] m, input int base);
        logic [2:0]  order [$];
        logic [11:0] exp_res [8];
        logic [7:0]  exp_v;
        logic [2:0]  ec;
        int          sum;
        int          bad;
        for (int c = 0; c < 8; c++) begin
            exp_res[c] = 12'h000;
            if (m[c]) order.push_back(c[2:0]);
        end
        exp_v = 8'h00; sum = 0; bad = 0;
        for (int k = 0; k < cmp_ch.size() - base; k++) begin
            ec = order[(k / 4) % order.size()];
            if (cmp_ch[base + k] !== ec) bad++;
            sum += int'(cmp_val[base + k]);
            if (k % 4 == 3) begin
                exp_res[ec] = 12'(sum / 4);
                exp_v[ec] = 1'b1;
                sum = 0;
            end
        end
        chk({tag, " scan order"}, bad, 0);
        chk({tag, " valid"}, valid, exp_v);
        for (int c = 0; c < 8; c++) begin
            rd_ch = c[2:0];
            tick();
            chk($sformatf("%s rd_data ch%0d", tag, c), rd_data, exp_res[c]);
        end
    endtask

    initial begin
        int         n;
        int         base;
        int         sd0;
        int         st0;
        logic [7:0] m;

        rst_n = 1'b0; en = 1'b0; ch_mask = 8'h00; rd_ch = 3'd0;
        #12;
        // Reset values
        chk("rst strt_cnv", strt_cnv, 0);
        chk("rst chnnl", chnnl, 0);
        chk("rst rd_data", rd_data, 0);
        chk("rst valid", valid, 0);
        chk("rst scan_done", scan_done, 0);
        chk("rst err", err, 0);
        do_reset();

        // Mask 05: four known samples on ch0, then move to ch2
        ch_mask = 8'h05; rd_ch = 3'd0;
        fixed_q = '{12'h100, 12'h104, 12'h108, 12'h10C};
        en = 1'b1;
        wait_for(1, 8'h01, 200, "m05 valid0", n);
        chk("m05 rd_data same cycle", rd_data, 12'h000);
        chk("m05 valid", valid, 8'h01);
        chk("m05 strt_cnv", strt_cnv, 1);
        chk("m05 next chnnl", chnnl, 3'd2);
        tick();
        chk("m05 rd_data ch0", rd_data, 12'h106);

        // Full-scale samples must not overflow
        do_reset();
        ch_mask = 8'h01; rd_ch = 3'd0;
        fixed_q = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        en = 1'b1;
        wait_for(2, 8'h00, 200, "fff scan_done", n);
        chk("fff valid", valid, 8'h01);
        tick();
        chk("fff rd_data", rd_data, 12'hFFF);
        chk("fff scan_done width", scan_done, 0);

        // Mask 81: single scan_done after ch7, then back to ch0
        do_reset();
        base = cmp_ch.size();
        sd0 = sd_cnt;
        ch_mask = 8'h81;
        en = 1'b1;
        wait_for(1, 8'h81, 400, "m81 valid", n);
        chk("m81 scan_done count", sd_cnt - sd0, 1);
        chk("m81 scan_done", scan_done, 1);
        chk("m81 restart chnnl", chnnl, 3'd0);
        en = 1'b0;
        repeat (10) tick();
        ref_check("m81", 8'h81, base);

        // Timeout on ch3, scanning continues on ch4
        do_reset();
        ch_mask = 8'h18; noresp = 8'h08;
        en = 1'b1;
        wait_for(0, 8'h00, 50, "tmo strt ch3", n);
        chk("tmo first chnnl", chnnl, 3'd3);
        tick();
        wait_for(3, 8'h00, 2000, "tmo err", n);
        chk("tmo latency", n + 1, TMO + 1);
        chk("tmo valid", valid, 8'h00);
        tick();
        chk("tmo strt after", strt_cnv, 1);
        chk("tmo chnnl after", chnnl, 3'd4);
        wait_for(1, 8'h10, 200, "tmo valid4", n);
        chk("tmo valid4", valid, 8'h10);
        chk("tmo err sticky", err, 1);
        en = 1'b0;
        tick(); tick();
        chk("tmo err clear", err, 0);

        // en dropped during the 2nd sample of ch1
        do_reset();
        ch_mask = 8'h02; rd_ch = 3'd1;
        fixed_q = '{12'h200, 12'h300, 12'h400, 12'h500};
        en = 1'b1;
        wait_for(1, 8'h02, 200, "abort valid1", n);
        tick();
        wait_for(0, 8'h00, 50, "abort 2nd strt", n);
        en = 1'b0;
        st0 = strt_cnt;
        repeat (10) tick();
        chk("abort no restart", strt_cnt - st0, 0);
        chk("abort valid", valid, 8'h02);
        rd_ch = 3'd0;
        tick();
        chk("abort rd ch0", rd_data, 12'h000);
        rd_ch = 3'd1;
        tick();
        chk("abort rd ch1", rd_data, 12'h380);
        fixed_q = '{12'h010, 12'h020, 12'h030, 12'h040};
        en = 1'b1;
        wait_for(2, 8'h00, 200, "abort resume", n);
        tick();
        chk("abort acc discarded", rd_data, 12'h028);

        // Reset mid-WAIT clears everything immediately
        do_reset();
        ch_mask = 8'h20; rd_ch = 3'd5; lat_lo = 20; lat_hi = 20;
        en = 1'b1;
        wait_for(1, 8'h20, 400, "rstw valid5", n);
        repeat (3) tick();
        chk("rstw pre rd_data nonzero", (rd_data === 12'h000) ? 0 : 1, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw strt_cnv", strt_cnv, 0);
        chk("rstw chnnl", chnnl, 0);
        chk("rstw rd_data", rd_data, 0);
        chk("rstw valid", valid, 0);
        chk("rstw scan_done", scan_done, 0);
        chk("rstw err", err, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (40) tick();
        chk("rstw no store valid", valid, 0);
        chk("rstw no store rd", rd_data, 0);

        // Random masks and latencies, two full passes each
        for (int it = 0; it < 3; it++) begin
            do_reset();
            m = 8'($urandom_range(255, 1));
            lat_lo = 1;
            lat_hi = $urandom_range(5, 1);
            base = cmp_ch.size();
            sd0 = sd_cnt;
            ch_mask = m;
            en = 1'b1;
            wait_for(2, 8'h00, 3000, "rnd pass1", n);
            tick();
            wait_for(2, 8'h00, 3000, "rnd pass2", n);
            en = 1'b0;
            repeat (20) tick();
            chk($sformatf("rnd%0d scan_done count", it), sd_cnt - sd0, 2);
            chk($sformatf("rnd%0d err", it), err, 0);
            ref_check($sformatf("rnd%0d", it), m, base);
        end

        chk("protocol violations", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2d_scanner.md
A2D_SCANNER -- requirements
Module: a2d_scanner

Interface
REQ-001 SHALL have parameter: TMO_CYC, 1023, WAIT cycles without cnv_cmplt before timeout.
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: en  input  1  scan enable, level.
REQ-005 SHALL have port: ch_mask  input  8  channels to scan, bit n = channel n.
REQ-006 SHALL have port: strt_cnv  output  1  one-cycle conversion start to A2D interface.
REQ-007 SHALL have port: chnnl  output  3  channel under conversion, held stable from strt_cnv until cnv_cmplt.
REQ-008 SHALL have port: cnv_cmplt  input  1  conversion complete level from A2D interface.
REQ-009 SHALL have port: res  input  12  conversion result, valid while cnv_cmplt high.
REQ-010 SHALL have port: rd_ch  input  3  read-port channel select.
REQ-011 SHALL have port: rd_data  output  12  averaged result for rd_ch, registered.
REQ-012 SHALL have port: valid  output  8  bit n set once channel n holds a result.
REQ-013 SHALL have port: scan_done  output  1  one-cycle pulse at end of each full pass.
REQ-014 SHALL have port: err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT, STORE.
REQ-016 IDLE -> START when en=1 and ch_mask!=0; else remain IDLE.
REQ-017 START: assert strt_cnv for exactly one cycle with chnnl=ptr; -> WAIT.
REQ-018 WAIT: cnv_cmplt=1 -> acc += res, sample count++, -> STORE if count reaches 4, else -> START on same channel.
REQ-019 STORE: result[ptr] <= acc[13:2] (truncating divide by 4), valid[ptr] <= 1, acc and count cleared, ptr advanced; -> START if en=1, else IDLE.
REQ-020 acc SHALL be 14 bits; no overflow for 4 x 12'hFFF.
REQ-021 Advance SHALL pick the next set bit of ch_mask above ptr in ascending order, wrapping 7 -> 0; ch_mask sampled only at advance.
REQ-022 scan_done SHALL pulse in the cycle following an advance whose new ptr <= old ptr (wrap); single-bit mask pulses every STORE.
REQ-023 Timeout: WAIT counter reaching TMO_CYC without cnv_cmplt SHALL set err, discard acc/count, leave valid unchanged, advance ptr.
REQ-024 en deasserted in START/WAIT: current conversion SHALL complete (or time out), accumulation discarded, no STORE, -> IDLE.
REQ-025 err SHALL clear only on reset or while en=0.
REQ-026 ch_mask=0 at an advance SHALL return FSM to IDLE with ptr unchanged.
REQ-027 rd_data SHALL register result[rd_ch] each cycle (1-cycle latency); same-cycle STORE to rd_ch yields old value, new value one cycle later.
REQ-028 strt_cnv SHALL never assert outside START; chnnl SHALL change only in STORE or IDLE.

Reset
REQ-029 Reset SHALL force: state IDLE, ptr 0, acc 0, count 0, strt_cnv 0, chnnl 0, rd_data 0, valid 8'h00, scan_done 0, err 0, all result regs 12'h000.
REQ-030 Reset mid-conversion SHALL abandon the conversion immediately; no STORE.

Verification
REQ-031 Mask 8'h05, A2D model returns 12'h100,12'h104,12'h108,12'h10C on ch0 -> result[0]=12'h106, valid=8'h01, next strt_cnv with chnnl=2.
REQ-032 Mask 8'h81, full pass ch0 then ch7 -> scan_done single pulse after ch7 STORE, ptr=0, valid=8'h81.
REQ-033 Four samples 12'hFFF -> result=12'hFFF, no overflow.
REQ-034 Model never asserts cnv_cmplt on ch3, mask 8'h18 -> err=1 after 1023 WAIT cycles, valid[3]=0, scanning continues on ch4.
REQ-035 en dropped during 2nd sample of ch1 -> conversion finishes, no STORE, IDLE, valid[1] unchanged; rd_ch=1 returns prior value 1 cycle later.
REQ-036 rst_n low during WAIT -> all outputs at REQ-029 values asynchronously.
